lcd_escritor: RTL and testbench

LCD_ESCRITOR -- requirements
Module: lcd_escritor

---
 rtl/lcd_pkg.sv | 56 +++++
 rtl/lcd_byte_tx.sv | 99 +++++++++
 rtl/lcd_escritor.sv | 152 +++++++++++++++
 tb/tb_lcd_escritor.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 word writer: state encoding, init
// command list, long-command codes and small helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    INIT  = 3'd1,
    IDLE  = 3'd2,
    SETUP = 3'd3,
    EHIGH = 3'd4,
    WAIT  = 3'd5,
    NEXT  = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam int unsigned WORD_BYTES = 11;
  localparam int unsigned INIT_BYTES = 4;
  localparam int unsigned IDX_W      = 4;

  // Element 0 goes out first: function set, display on, entry mode, clear.
  localparam logic [INIT_BYTES-1:0][7:0] INIT_CMDS = {8'h01, 8'h06, 8'h0C, 8'h38};
  localparam logic [2:0][7:0]            LONG_CMDS = {8'h03, 8'h02, 8'h01};

  function automatic logic is_long_cmd(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (b == LONG_CMDS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] byte_at(input logic [8*WORD_BYTES-1:0] w,
                                         input logic [IDX_W-1:0] k);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (k == IDX_W'(i)) b = w[8*i +: 8];
    end
    return b;
  endfunction

  function automatic logic rs_at(input logic [WORD_BYTES-1:0] r, input logic [IDX_W-1:0] k);
    logic v;
    v = 1'b0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (k == IDX_W'(i)) v = r[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Single-byte HD44780 write: SETUP (E low), EHIGH (E high), WAIT (E low).
// ack_c_o marks the last WAIT cycle; a go in that cycle chains with no gap.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned E_HIGH_CYC    = 25,
  parameter int unsigned WAIT_CYC      = 2500,
  parameter int unsigned LONG_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go_i,
  input  logic [7:0] byte_i,
  input  logic       rs_i,
  output logic       ack_c_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_e_o
);

  localparam int unsigned MAX_CYC = max_u(max_u(SETUP_CYC, E_HIGH_CYC),
                                          max_u(WAIT_CYC, LONG_WAIT_CYC));
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT_CYC - 1);

  state_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] wait_last_c;

  assign wait_last_c = long_q ? LONG_LAST : WAIT_LAST;
  assign ack_c_o     = (phase_q == WAIT) && (cnt_q == wait_last_c);
  assign lcd_data_o  = data_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_e_o     = e_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + CNT_W'(1);
    data_d  = data_q;
    rs_d    = rs_q;
    e_d     = e_q;
    long_d  = long_q;

    case (phase_q)
      SETUP: if (cnt_q == SETUP_LAST) begin
        phase_d = EHIGH;
        cnt_d   = '0;
        e_d     = 1'b1;
      end
      EHIGH: if (cnt_q == EHIGH_LAST) begin
        phase_d = WAIT;
        cnt_d   = '0;
        e_d     = 1'b0;
      end
      WAIT: if (ack_c_o) begin
        phase_d = IDLE;
        cnt_d   = '0;
      end
      default: cnt_d = '0;
    endcase

    // Load the next byte; data and RS stay put while idle.
    if (go_i && ((phase_q == IDLE) || ack_c_o)) begin
      phase_d = SETUP;
      cnt_d   = '0;
      data_d  = byte_i;
      rs_d    = rs_i;
      e_d     = 1'b0;
      long_d  = !rs_i && is_long_cmd(byte_i);
    end
  end

endmodule

// File: rtl/lcd_escritor.sv
// HD44780 word writer: power-up delay, 4-command init, then 11-byte words
// on request, sequenced through lcd_byte_tx.
module lcd_escritor
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC   = 750000,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned E_HIGH_CYC    = 25,
  parameter int unsigned WAIT_CYC      = 2500,
  parameter int unsigned LONG_WAIT_CYC = 82000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [8*WORD_BYTES-1:0] palavra,
  input  logic [WORD_BYTES-1:0]   RS_list,
  output logic [7:0]              lcd_data,
  output logic                    lcd_rs,
  output logic                    lcd_rw,
  output logic                    lcd_e,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned PWR_W = $clog2(POWERUP_CYC + 1);
  localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(POWERUP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_BYTES - 1);
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(INIT_BYTES - 1);

  state_t                  state_q, state_d;
  logic [PWR_W-1:0]        pwr_cnt_q, pwr_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [WORD_BYTES-1:0]   rsl_q, rsl_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    go_c, ack_c, tx_rs_c;
  logic [7:0]              tx_byte_c;
  logic [IDX_W-1:0]        nxt_idx_c;

  lcd_byte_tx #(
    .SETUP_CYC    (SETUP_CYC),
    .E_HIGH_CYC   (E_HIGH_CYC),
    .WAIT_CYC     (WAIT_CYC),
    .LONG_WAIT_CYC(LONG_WAIT_CYC)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .go_i      (go_c),
    .byte_i    (tx_byte_c),
    .rs_i      (tx_rs_c),
    .ack_c_o   (ack_c),
    .lcd_data_o(lcd_data),
    .lcd_rs_o  (lcd_rs),
    .lcd_e_o   (lcd_e)
  );

  assign lcd_rw = 1'b0;
  assign busy   = busy_q;
  assign done   = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= PWRUP;
      pwr_cnt_q <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      rsl_q     <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwr_cnt_q <= pwr_cnt_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      rsl_q     <= rsl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next byte is handed to the transmitter in its ack cycle, so NEXT costs no cycles.
  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    idx_d     = idx_q;
    word_d    = word_q;
    rsl_d     = rsl_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    go_c      = 1'b0;
    tx_byte_c = '0;
    tx_rs_c   = 1'b0;
    nxt_idx_c = idx_q + IDX_W'(1);

    case (state_q)
      PWRUP: begin
        if (pwr_cnt_q == PWR_LAST) begin
          state_d   = INIT;
          idx_d     = '0;
          go_c      = 1'b1;
          tx_byte_c = INIT_CMDS[0];
        end else begin
          pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
        end
      end
      INIT: begin
        if (ack_c) begin
          if (idx_q == INIT_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end else begin
            idx_d     = nxt_idx_c;
            go_c      = 1'b1;
            tx_byte_c = INIT_CMDS[nxt_idx_c[1:0]];
          end
        end
      end
      IDLE: begin
        if (start) begin
          state_d   = NEXT;
          word_d    = palavra;
          rsl_d     = RS_list;
          idx_d     = '0;
          busy_d    = 1'b1;
          go_c      = 1'b1;
          tx_byte_c = palavra[7:0];
          tx_rs_c   = RS_list[0];
        end
      end
      NEXT: begin
        if (ack_c) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d     = nxt_idx_c;
            go_c      = 1'b1;
            tx_byte_c = byte_at(word_q, nxt_idx_c);
            tx_rs_c   = rs_at(rsl_q, nxt_idx_c);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_escritor.sv
// Bench for lcd_escritor: cycle-level behavioural model compared every cycle,
// plus directed strobe-list and timing checks on short parameters.
module tb_lcd_escritor;

  localparam int unsigned P_PWR = 5;
  localparam int unsigned P_SET = 2;
  localparam int unsigned P_EH  = 3;
  localparam int unsigned P_WT  = 4;
  localparam int unsigned P_LW  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [87:0] palavra = '0;
  logic [10:0] RS_list = '0;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_e, busy, done;

  always #5 clk = ~clk;

  lcd_escritor #(
    .POWERUP_CYC  (P_PWR),
    .SETUP_CYC    (P_SET),
    .E_HIGH_CYC   (P_EH),
    .WAIT_CYC     (P_WT),
    .LONG_WAIT_CYC(P_LW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .palavra (palavra),
    .RS_list (RS_list),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .busy    (busy),
    .done    (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int byte_len(input logic [7:0] d, input logic rs);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return int'(P_SET + P_EH + P_LW);
    return int'(P_SET + P_EH + P_WT);
  endfunction

  // Behavioural model: a queue of pending bytes, each occupying byte_len cycles.
  typedef enum {K_PW, K_INIT, K_IDLE, K_WORD, K_DONE} kind_t;
  kind_t      kind = K_PW;
  int         pw_left = 0;
  logic [7:0] q_d[$];
  logic       q_r[$];
  bit         sending = 0;
  int         t = 0;
  int         cur_len = 0;
  logic [7:0] m_data = '0;
  logic       m_rs = 1'b0, m_busy = 1'b1, m_done = 1'b0;
  bit         model_valid = 0;
  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  task automatic model_start_next();
    m_data  = q_d.pop_front();
    m_rs    = q_r.pop_front();
    t       = 0;
    cur_len = byte_len(m_data, m_rs);
    sending = 1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      kind = K_PW; pw_left = int'(P_PWR);
      q_d.delete(); q_r.delete();
      sending = 0; t = 0; m_data = '0; m_rs = 1'b0;
      m_busy = 1'b1; m_done = 1'b0; model_valid = 1;
    end else begin
      m_done = 1'b0;
      if (kind == K_PW) begin
        pw_left--;
        if (pw_left == 0) begin
          for (int i = 0; i < 4; i++) begin q_d.push_back(init_cmds[i]); q_r.push_back(1'b0); end
          kind = K_INIT;
          model_start_next();
        end
      end else if (sending) begin
        t++;
        if (t == cur_len) begin
          if (q_d.size() > 0) model_start_next();
          else begin
            sending = 0; m_busy = 1'b0;
            if (kind == K_WORD) begin m_done = 1'b1; kind = K_DONE; end
            else kind = K_IDLE;
          end
        end
      end else if (kind == K_DONE) begin
        kind = K_IDLE;
      end else if (kind == K_IDLE && start) begin
        for (int k = 0; k < 11; k++) begin q_d.push_back(palavra[8*k +: 8]); q_r.push_back(RS_list[k]); end
        m_busy = 1'b1; kind = K_WORD;
        model_start_next();
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic exp_e;
    if (model_valid) begin
      exp_e = sending && (t >= int'(P_SET)) && (t < int'(P_SET + P_EH));
      n_cmp++;
      if ({lcd_e, lcd_data, lcd_rs, busy, done, lcd_rw} !== {exp_e, m_data, m_rs, m_busy, m_done, 1'b0}) begin
        n_bad++;
        $display("FAIL outputs @%0t: got e=%b data=%h rs=%b busy=%b done=%b rw=%b, expected e=%b data=%h rs=%b busy=%b done=%b rw=0",
                 $time, lcd_e, lcd_data, lcd_rs, busy, done, lcd_rw, exp_e, m_data, m_rs, m_busy, m_done);
      end
    end
  end

  // Strobe capture: data/RS at the rising E and the length of each E-high run.
  logic [7:0] cap_d[$];
  logic       cap_r[$];
  int         cap_len[$];
  logic       prev_e = 1'b0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
      cap_d.push_back(lcd_data); cap_r.push_back(lcd_rs); cap_len.push_back(1);
    end else if (lcd_e === 1'b1 && cap_len.size() > 0) begin
      cap_len[cap_len.size()-1]++;
    end
    if (done === 1'b1) done_cnt++;
    prev_e = lcd_e;
  end

  logic [7:0] exp_d[$];
  logic       exp_r[$];

  task automatic clear_cap();
    @(posedge clk); #1;
    cap_d.delete(); cap_r.delete(); cap_len.delete(); done_cnt = 0;
  endtask

  task automatic build_exp(input logic [87:0] w, input logic [10:0] r);
    exp_d.delete(); exp_r.delete();
    for (int k = 0; k < 11; k++) begin exp_d.push_back(w[8*k +: 8]); exp_r.push_back(r[k]); end
  endtask

  function automatic int word_busy(input logic [87:0] w, input logic [10:0] r);
    int s = 0;
    for (int k = 0; k < 11; k++) s += byte_len(w[8*k +: 8], r[k]);
    return s;
  endfunction

  task automatic check_strobes(input string name);
    check({name, "_count"}, 64'(cap_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++)
      check($sformatf("%s_strobe%0d", name, i), {cap_d[i], 7'(cap_r[i]), 8'(cap_len[i])},
            {exp_d[i], 7'(exp_r[i]), 8'(P_EH)});
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1 start = 1'b1;
    repeat (n) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int busy_cyc);
    bit ok = 0;
    busy_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin ok = 1; break; end
    end
    check("done_within_budget", 64'(ok), 64'd1);
  endtask

  // Called with rst_n just released; checks power-up delay and init strobes.
  task automatic run_init_checks(input string name);
    int pre = 0, bc = 0;
    bit seen_e = 0, ok = 0;
    cap_d.delete(); cap_r.delete(); cap_len.delete();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lcd_e === 1'b1) seen_e = 1;
      if (!seen_e) pre++;
      if (busy === 1'b1) bc++;
      else begin ok = 1; break; end
    end
    check({name, "_idle_reached"}, 64'(ok), 64'd1);
    check({name, "_pre_strobe_cycles"}, 64'(pre), 64'd7);
    check({name, "_busy_cycles"}, 64'(bc), 64'd47);
    exp_d.delete(); exp_r.delete();
    for (int i = 0; i < 4; i++) begin exp_d.push_back(init_cmds[i]); exp_r.push_back(1'b0); end
    check_strobes(name);
  endtask

  logic [7:0]  add_bytes [11] = '{8'h41, 8'h44, 8'h44, 8'h89, 8'h5B, 8'h30, 8'h30, 8'h31, 8'h31, 8'h5D, 8'h02};
  logic [7:0]  clr_bytes [11] = '{8'h43, 8'h4C, 8'h45, 8'h41, 8'h52, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};

  function automatic logic [87:0] rand_word();
    logic [87:0] w;
    for (int k = 0; k < 11; k++)
      w[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
    return w;
  endfunction

  initial begin
    int bc, rises;
    logic [87:0] w;
    logic [10:0] r;
    bit hit;

    // Reset release, power-up delay and init sequence.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_init_checks("init");

    // ADD word.
    for (int k = 0; k < 11; k++) palavra[8*k +: 8] = add_bytes[k];
    RS_list = 11'b01111110111;
    build_exp(palavra, RS_list);
    clear_cap();
    pulse_start(1);
    wait_done(400, bc);
    check("add_busy_cycles", 64'(bc), 64'd105);
    @(posedge clk); #1;
    check_strobes("add");
    check("add_done_pulses", 64'(done_cnt), 64'd1);

    // start held for 3 cycles, then pulsed again mid-word.
    w = rand_word(); r = 11'($urandom);
    palavra = w; RS_list = r;
    build_exp(w, r);
    clear_cap();
    pulse_start(3);
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400, bc);
    repeat (60) @(posedge clk);
    #1;
    check_strobes("hold");
    check("hold_done_pulses", 64'(done_cnt), 64'd1);

    // Inputs change one cycle after acceptance.
    w = rand_word(); r = 11'($urandom);
    palavra = w; RS_list = r;
    build_exp(w, r);
    clear_cap();
    pulse_start(1);
    palavra = ~w; RS_list = ~r;
    wait_done(400, bc);
    check("latch_busy_cycles", 64'(bc), 64'(word_busy(w, r)));
    @(posedge clk); #1;
    check_strobes("latch");

    // CLEAR word: long waits on bytes 5..10.
    for (int k = 0; k < 11; k++) palavra[8*k +: 8] = clr_bytes[k];
    RS_list = 11'b00000011111;
    build_exp(palavra, RS_list);
    clear_cap();
    pulse_start(1);
    wait_done(400, bc);
    check("clear_busy_cycles", 64'(bc), 64'd135);
    @(posedge clk); #1;
    check_strobes("clear");

    // Reset during the E strobe of byte 4.
    palavra = rand_word(); RS_list = 11'($urandom);
    clear_cap();
    pulse_start(1);
    rises = 0; hit = 0; prev_e = prev_e;
    for (int i = 0; i < 300; i++) begin
      logic pe;
      pe = lcd_e;
      @(negedge clk);
      if (lcd_e === 1'b1 && pe !== 1'b1) rises++;
      if (rises == 5) begin hit = 1; break; end
    end
    check("byte4_strobe_seen", 64'(hit), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_drops_e", 64'(lcd_e), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    done_cnt = 0;
    run_init_checks("reinit");
    check("reinit_no_done", 64'(done_cnt), 64'd0);

    // Randomized words, stray starts, input churn and one random reset.
    for (int it = 0; it < 10; it++) begin
      w = rand_word(); r = 11'($urandom);
      palavra = w; RS_list = r;
      build_exp(w, r);
      clear_cap();
      pulse_start($urandom_range(1, 3));
      palavra = rand_word(); RS_list = 11'($urandom);
      repeat ($urandom_range(5, 60)) @(posedge clk);
      if (it == 6) begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_init_checks("rand_reinit");
      end else begin
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(400, bc);
        @(posedge clk); #1;
        check_strobes($sformatf("rand%0d", it));
        check($sformatf("rand%0d_done_pulses", it), 64'(done_cnt), 64'd1);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
